// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the elastic register pipeline: occupancy counter sizing
// and the default word loaded into data registers on reset or flush.
package reg_pipe_pkg;

   localparam int unsigned DEFAULT_RESET_VAL = 0;

   // Counter must represent 0..stages inclusive.
   function automatic int occ_width(input int stages);
      return (stages < 1) ? 1 : $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One elastic stage: a valid bit plus a data register that advances whenever
// the stage is empty or its downstream neighbour is taking the current word.
module reg_pipe_stage
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_up_valid,
   input  logic [WIDTH-1:0] i_up_data,
   input  logic             i_dn_ready,
   output logic             o_rdy,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_v;
   logic [WIDTH-1:0] r_d;

   // An empty stage always accepts, collapsing bubbles without waiting on the consumer.
   assign o_rdy   = ~r_v | i_dn_ready;
   assign o_valid = r_v;
   assign o_data  = r_d;

   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_v <= 1'b0;
         r_d <= RESET_VAL;
      end else if (o_rdy) begin
         r_v <= i_up_valid;
         if (i_up_valid) begin
            r_d <= i_up_data;
         end
      end
   end

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline: STAGES chained valid/data stages with a combinational
// ready chain, synchronous flush and a registered occupancy count.
module reg_pipe
   import reg_pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [WIDTH-1:0]                data_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                data_out,
   output logic [occ_width(STAGES)-1:0]    occupancy
);

   localparam int OCC_W = occ_width(STAGES);

   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] r_occ;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;
      logic             w_dn_ready;
      logic             w_rdy;
      logic             w_v;
      logic [WIDTH-1:0] w_d;

      if (gi == 0) begin : g_head
         assign w_up_valid = in_valid & ~flush;
         assign w_up_data  = data_in;
      end else begin : g_body
         assign w_up_valid = g_stage[gi-1].w_v;
         assign w_up_data  = g_stage[gi-1].w_d;
      end

      if (gi == STAGES - 1) begin : g_tail
         assign w_dn_ready = out_ready;
      end else begin : g_link
         assign w_dn_ready = g_stage[gi+1].w_rdy;
      end

      reg_pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_flush    (flush),
         .i_up_valid (w_up_valid),
         .i_up_data  (w_up_data),
         .i_dn_ready (w_dn_ready),
         .o_rdy      (w_rdy),
         .o_valid    (w_v),
         .o_data     (w_d)
      );
   end

   assign in_ready  = g_stage[0].w_rdy & ~flush;
   assign out_valid = g_stage[STAGES-1].w_v;
   assign data_out  = g_stage[STAGES-1].w_d;
   assign occupancy = r_occ;

   assign w_push = in_valid & in_ready;
   assign w_pop  = out_valid & out_ready;

   // Tracks popcount of the valid bits by following the boundary handshakes.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         r_occ <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe: a 3-stage instance driven through latency, streaming,
// back-pressure and randomized bubble/flush traffic, plus a 4-stage instance for flush.
module tb_reg_pipe;

   localparam int             W   = 32;
   localparam int             SA  = 3;
   localparam int             SB  = 4;
   localparam logic [W-1:0]   RVA = 32'hDEAD_BEEF;
   localparam logic [W-1:0]   RVB = 32'h5A5A_0F0F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic                      a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [W-1:0]              a_data_in, a_data_out;
   logic [$clog2(SA+1)-1:0]   a_occ;

   logic                      b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [W-1:0]              b_data_in, b_data_out;
   logic [$clog2(SB+1)-1:0]   b_occ;

   reg_pipe #(.WIDTH(W), .STAGES(SA), .RESET_VAL(RVA)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (a_flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .data_in   (a_data_in),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .data_out  (a_data_out),
      .occupancy (a_occ)
   );

   reg_pipe #(.WIDTH(W), .STAGES(SB), .RESET_VAL(RVB)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .data_in   (b_data_in),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .data_out  (b_data_out),
      .occupancy (b_occ)
   );

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] sb[$];
   logic         a_cur_push = 1'b0;
   int           pop_count = 0;
   logic [W-1:0] mon_exp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: words in flight are exactly the accepted-but-undelivered queue.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("occupancy", 64'(a_occ), 64'(sb.size() - int'(a_cur_push)));
         if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_output: got 0x%0h with no word outstanding", a_data_out);
            end else begin
               mon_exp = sb.pop_front();
               chk("data_out", 64'(a_data_out), 64'(mon_exp));
               pop_count++;
            end
         end
         if (a_flush === 1'b1) sb.delete();
      end
   end

   task automatic cyc_a(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic fl, output logic acc);
      logic exp_rdy;
      @(posedge clk);
      #1;
      a_in_valid  = v;
      a_data_in   = d;
      a_out_ready = ordy;
      a_flush     = fl;
      #1;
      exp_rdy = !fl && ((sb.size() < SA) || ordy);
      chk("in_ready", 64'(a_in_ready), 64'(exp_rdy));
      acc = (rst_n === 1'b1) && a_in_valid && (a_in_ready === 1'b1);
      if (acc) sb.push_back(d);
      a_cur_push = acc;
   endtask

   task automatic cyc_b(input logic v, input logic [W-1:0] d, input logic ordy,
                        input logic fl, output logic acc);
      @(posedge clk);
      #1;
      b_in_valid  = v;
      b_data_in   = d;
      b_out_ready = ordy;
      b_flush     = fl;
      #1;
      acc = (rst_n === 1'b1) && b_in_valid && (b_in_ready === 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got %0d vectors, required completion", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   lat, p0, stalls, n_acc, acc_cnt, first, nvalid;

      rst_n       = 1'b0;
      a_in_valid  = 1'b1; a_data_in = 32'hFFFF_0000; a_out_ready = 1'b1; a_flush = 1'b0;
      b_in_valid  = 1'b1; b_data_in = 32'hFFFF_0001; b_out_ready = 1'b1; b_flush = 1'b0;

      repeat (2) begin
         @(posedge clk);
         #2;
         chk("rst_a_valid", 64'(a_out_valid), 64'(0));
         chk("rst_a_data",  64'(a_data_out),  64'(RVA));
         chk("rst_a_occ",   64'(a_occ),       64'(0));
         chk("rst_b_valid", 64'(b_out_valid), 64'(0));
         chk("rst_b_data",  64'(b_data_out),  64'(RVB));
         chk("rst_b_occ",   64'(b_occ),       64'(0));
      end
      rst_n      = 1'b1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      chk("post_rst_valid", 64'(a_out_valid), 64'(0));
      chk("post_rst_occ",   64'(a_occ),       64'(0));

      // Latency of a single word through an empty pipe.
      cyc_a(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, acc);
      chk("lat_accept", 64'(acc), 64'(1));
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
         if (a_out_valid === 1'b1 && lat == 0) begin
            lat = k;
            chk("lat_data", 64'(a_data_out), 64'(32'hA5A5_0001));
         end
      end
      chk("latency", 64'(lat), 64'(SA));

      // Back-to-back stream at full throughput.
      p0     = pop_count;
      stalls = 0;
      for (int k = 0; k < 100; k++) begin
         cyc_a(1'b1, 32'(k), 1'b1, 1'b0, acc);
         if (!acc) stalls++;
      end
      repeat (SA) cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      chk("stream_stalls", 64'(stalls), 64'(0));
      chk("stream_pops",   64'(pop_count - p0), 64'(100));

      // Back-pressure fill then drain.
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         cyc_a(1'b1, 32'(32'h1000 + i), 1'b0, 1'b0, acc);
         if (!acc) break;
         n_acc++;
      end
      chk("bp_held",     64'(n_acc),      64'(SA));
      chk("bp_occ",      64'(a_occ),      64'(SA));
      chk("bp_in_ready", 64'(a_in_ready), 64'(0));
      for (int i = 0; i < 20 && sb.size() != 0; i++) cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      chk("bp_drain",       64'(sb.size()),   64'(0));
      chk("bp_empty_valid", 64'(a_out_valid), 64'(0));

      // Random bubbles, back-pressure and occasional flush.
      acc_cnt = 0;
      for (int c = 0; c < 20000 && acc_cnt < 1000; c++) begin
         cyc_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 63) == 0), acc);
         if (acc) acc_cnt++;
      end
      chk("bubble_words", 64'(acc_cnt), 64'(1000));
      for (int i = 0; i < 20 && sb.size() != 0; i++) cyc_a(1'b0, '0, 1'b1, 1'b0, acc);
      chk("bubble_drain", 64'(sb.size()), 64'(0));
      cyc_a(1'b0, '0, 1'b1, 1'b0, acc);

      // Flush a partly filled 4-stage pipe, then send one fresh word.
      n_acc = 0;
      for (int i = 0; i < 3; i++) begin
         cyc_b(1'b1, 32'(32'h11 * (i + 1)), 1'b0, 1'b0, acc);
         if (acc) n_acc++;
      end
      chk("fl_fill", 64'(n_acc), 64'(3));
      cyc_b(1'b1, 32'h99, 1'b0, 1'b1, acc);
      chk("fl_in_ready",   64'(b_in_ready), 64'(0));
      chk("fl_occ_before", 64'(b_occ),      64'(3));
      cyc_b(1'b0, '0, 1'b0, 1'b0, acc);
      chk("fl_out_valid", 64'(b_out_valid), 64'(0));
      chk("fl_occ",       64'(b_occ),       64'(0));
      chk("fl_data",      64'(b_data_out),  64'(RVB));
      cyc_b(1'b1, 32'h1234, 1'b1, 1'b0, acc);
      chk("fl_new_accept", 64'(acc), 64'(1));
      first  = 0;
      nvalid = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc_b(1'b0, '0, 1'b1, 1'b0, acc);
         if (b_out_valid === 1'b1) begin
            nvalid++;
            if (first == 0) begin
               first = k;
               chk("fl_new_data", 64'(b_data_out), 64'(32'h1234));
            end
         end
      end
      chk("fl_new_latency", 64'(first),  64'(SB));
      chk("fl_new_alone",   64'(nvalid), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
